uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one uart_tx instance between N_REQ byte producers (e.g. debug console, status reporter, register dump).
- Accepts one byte per grant over a valid/ready handshake.
- Sequences uart_tx through the tx_start / tx_busy / tx_done protocol.
- Reports per-requester completion and a watchdog timeout if the transmitter never finishes.

---
 rtl/uart_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/uart_tx_sched.sv | 104 ++++++++++
 tb/tb_uart_tx_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit scheduler
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int DEFAULT_TIMEOUT = 65536;
  typedef enum logic [1:0] {IDLE, START, WAIT} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i with wrap-around
// req_i  request vector
// ptr_i  index with highest priority
// gnt_o  one-hot grant, zero when no request
// idx_o  index of the granted request, zero when none
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    // walk from lowest to highest priority so the nearest request overwrites the rest
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx among N_REQ byte producers
// req_valid/req_data/req_ready  per-requester byte handshake, one-hot ready
// req_done                      one-cycle pulse when the granted byte left the line
// grant_id, sched_busy          current/last grant and non-idle indication
// err_timeout, err_clr          sticky watchdog error and its clear
// tx_start/tx_data/tx_busy/tx_done  uart_tx interface
module uart_tx_sched #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = uart_pkg::DATA_W,
  parameter int TIMEOUT_CYC = uart_pkg::DEFAULT_TIMEOUT,
  parameter int CNT_W       = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         req_done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     sched_busy,
  output logic                     err_timeout,
  input  logic                     err_clr,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done
);
  import uart_pkg::*;
  localparam int IW = $clog2(N_REQ);
  sched_state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, gid_q, gid_d, arb_idx, rr_next;
  logic [N_REQ-1:0] arb_gnt, done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic err_q, err_d, timeout;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );
  // fires on the last of TIMEOUT_CYC cycles spent in WAIT
  assign timeout     = (TIMEOUT_CYC != 0) && (wd_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rr_next     = IW'((int'(gid_q) + 1) % N_REQ);
  assign req_ready   = (state_q == IDLE && !tx_busy && !rst) ? arb_gnt : '0;
  assign tx_start    = state_q == START;
  assign sched_busy  = state_q != IDLE;
  assign tx_data     = data_q;
  assign grant_id    = gid_q;
  assign req_done    = done_q;
  assign err_timeout = err_q;
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    wd_d    = wd_q;
    done_d  = '0;
    err_d   = err_clr ? 1'b0 : err_q;
    case (state_q)
      IDLE: begin
        if (|req_valid && !tx_busy) begin
          state_d = START;
          gid_d   = arb_idx;
          data_d  = req_data[arb_idx*DATA_W +: DATA_W];
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // a completion on the timeout cycle takes precedence over the error
        if (tx_done) done_d[gid_q] = 1'b1;
        else if (timeout) err_d = 1'b1;
        if (tx_done || timeout) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched with a behavioural uart_tx stand-in
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_ready, req_done;
  logic [1:0] grant_id;
  logic sched_busy, err_timeout, tx_start;
  logic err_clr = 1'b0;
  logic [7:0] tx_data;
  logic tx_busy = 1'b0;
  logic tx_done = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  uart_tx_sched #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(50), .CNT_W(17)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // called in the START cycle; returns in the cycle after tx_done
  task automatic frame(input int n, input logic [7:0] d, input logic [3:0] exp_done);
    tx_busy = 1'b1;
    tick();
    chk("start_one_cycle", {31'd0, tx_start}, 32'd0);
    repeat (n - 1) tick();
    chk("tx_data_hold", {24'd0, tx_data}, {24'd0, d});
    chk("wait_no_done", {28'd0, req_done}, 32'd0);
    tx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
    chk("req_done", {28'd0, req_done}, {28'd0, exp_done});
    chk("idle_after_done", {31'd0, sched_busy}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout vectors=%0d", vectors);
    $fatal(1);
  end
  initial begin
    req_valid = 4'b0001;
    tick();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_done", {28'd0, req_done}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_busy", {31'd0, sched_busy}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    req_valid = 4'b0001;
    req_data = 32'h0000_0055;
    #1 chk("t1_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    chk("t1_start", {31'd0, tx_start}, 32'd1);
    chk("t1_data", {24'd0, tx_data}, 32'h55);
    chk("t1_grant", {30'd0, grant_id}, 32'd0);
    chk("t1_busy", {31'd0, sched_busy}, 32'd1);
    frame(4, 8'h55, 4'b0001);
    tick();
    chk("t1_done_pulse_len", {28'd0, req_done}, 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_tx_done_busy", {31'd0, sched_busy}, 32'd0);
    tick();
    chk("idle_tx_done_ignored", {28'd0, req_done}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data = 32'hA3A2_A1A0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ready", {28'd0, req_ready}, 32'd1 << i);
      tick();
      chk("t2_start", {31'd0, tx_start}, 32'd1);
      chk("t2_grant", {30'd0, grant_id}, i);
      chk("t2_data", {24'd0, tx_data}, 32'hA0 + i);
      req_valid[i] = 1'b0;
      frame(3, 8'hA0 + 8'(i), 4'(1 << i));
    end
    req_data = 32'hB300_B100;
    req_valid = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      #1 chk("t3_ready", {28'd0, req_ready}, (j % 2) ? 32'h8 : 32'h2);
      tick();
      chk("t3_grant", {30'd0, grant_id}, (j % 2) ? 32'd3 : 32'd1);
      frame(2, (j % 2) ? 8'hB3 : 8'hB1, (j % 2) ? 4'b1000 : 4'b0010);
    end
    req_valid = '0;
    req_data = 32'hD3D2_D1D0;
    req_valid = 4'b0101;
    #1 chk("t4_ready", {28'd0, req_ready}, 32'h1);
    tick();
    chk("t4_start", {31'd0, tx_start}, 32'd1);
    req_valid = 4'b0100;
    tx_busy = 1'b1;
    repeat (50) tick();
    chk("t4_err_before", {31'd0, err_timeout}, 32'd0);
    chk("t4_busy_before", {31'd0, sched_busy}, 32'd1);
    chk("t4_ready_in_wait", {28'd0, req_ready}, 32'd0);
    tick();
    chk("t4_err_set", {31'd0, err_timeout}, 32'd1);
    chk("t4_idle", {31'd0, sched_busy}, 32'd0);
    chk("t4_no_done", {28'd0, req_done}, 32'd0);
    tx_busy = 1'b0;
    #1 chk("t4_next_ready", {28'd0, req_ready}, 32'h4);
    tick();
    chk("t4_next_grant", {30'd0, grant_id}, 32'd2);
    chk("t4_err_sticky", {31'd0, err_timeout}, 32'd1);
    req_valid = '0;
    err_clr = 1'b1;
    tx_busy = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", {31'd0, err_timeout}, 32'd0);
    tx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
    chk("t4_done_after_clr", {28'd0, req_done}, 32'h4);
    req_valid = 4'b1000;
    #1 chk("tie_ready", {28'd0, req_ready}, 32'h8);
    tick();
    chk("tie_start", {31'd0, tx_start}, 32'd1);
    req_valid = '0;
    tx_busy = 1'b1;
    repeat (50) tick();
    tx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
    chk("tie_no_err", {31'd0, err_timeout}, 32'd0);
    chk("tie_done", {28'd0, req_done}, 32'h8);
    tx_busy = 1'b1;
    req_valid = 4'b0010;
    #1 chk("t6_ready_blocked", {28'd0, req_ready}, 32'd0);
    tick();
    chk("t6_ready_still_blocked", {28'd0, req_ready}, 32'd0);
    chk("t6_idle", {31'd0, sched_busy}, 32'd0);
    tx_busy = 1'b0;
    #1 chk("t6_ready_released", {28'd0, req_ready}, 32'h2);
    tick();
    chk("t6_grant", {30'd0, grant_id}, 32'd1);
    chk("t6_start", {31'd0, tx_start}, 32'd1);
    req_valid = '0;
    frame(2, 8'hD1, 4'b0010);
    req_data = 32'h0000_003C;
    req_valid = 4'b0001;
    tick();
    chk("t5_data", {24'd0, tx_data}, 32'h3C);
    req_valid = '0;
    tx_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("t5_rst_start", {31'd0, tx_start}, 32'd0);
    chk("t5_rst_busy", {31'd0, sched_busy}, 32'd0);
    chk("t5_rst_data", {24'd0, tx_data}, 32'd0);
    chk("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    tick();
    chk("t5_rst_no_done", {28'd0, req_done}, 32'd0);
    rst = 1'b0;
    tx_busy = 1'b0;
    req_valid = 4'b0011;
    #1 chk("t5_ready_ptr0", {28'd0, req_ready}, 32'h1);
    tick();
    chk("t5_regrant", {30'd0, grant_id}, 32'd0);
    chk("t5_redata", {24'd0, tx_data}, 32'h3C);
    req_valid = '0;
    frame(2, 8'h3C, 4'b0001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
